// File: rtl/x_adc_pkg.sv
// Shared constants and state encoding for the x_adc mux controllers.
package x_adc_pkg;

  localparam int NUM_CH  = 32;
  localparam int SEL_W   = 5;
  localparam int DWELL_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

endpackage

// File: rtl/x_adc_next_ch.sv
// Combinational channel finder: next set mask bit above cur, and the lowest set bit.
module x_adc_next_ch
  import x_adc_pkg::*;
(
  input  logic [NUM_CH-1:0] mask,
  input  logic [SEL_W-1:0]  cur,
  output logic [SEL_W-1:0]  next_idx,
  output logic              has_next,
  output logic [SEL_W-1:0]  lowest_idx
);

  // Scan downward so the last hit is the smallest qualifying index.
  always_comb begin
    next_idx   = '0;
    has_next   = 1'b0;
    lowest_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i] && (i > int'(cur))) begin
        next_idx = SEL_W'(i);
        has_next = 1'b1;
      end
      if (mask[i]) begin
        lowest_idx = SEL_W'(i);
      end
    end
  end

endmodule

// File: rtl/x_adc_sweep_sched.sv
// Sweep scheduler for the 32-channel x_adc mux: rotates the select through an
// enabled mask with programmable dwell and tags samples at the mux output.
module x_adc_sweep_sched
  import x_adc_pkg::*;
(
  input  logic               clk,
  input  logic               GlobalReset,
  input  logic [NUM_CH-1:0]  ch_enable,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               start,
  input  logic               stop,
  input  logic               single,
  output logic [SEL_W-1:0]   x_adc_select,
  output logic               sample_valid,
  output logic [SEL_W-1:0]   sample_ch,
  output logic               sweep_done,
  output logic               busy,
  output logic               err_empty
);

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [NUM_CH-1:0]  act_mask_q, act_mask_d;
  logic [DWELL_W-1:0] dwell_l_q, dwell_l_d;
  logic               single_l_q, single_l_d;
  logic               stop_pending_q, stop_pending_d;
  logic               sample_valid_q, sample_valid_d;
  logic [SEL_W-1:0]   sample_ch_q, sample_ch_d;
  logic               sweep_done_q, sweep_done_d;
  logic               err_empty_q, err_empty_d;

  logic               issue;
  logic               sweep_end;
  logic               err;
  logic [SEL_W-1:0]   next_idx;
  logic               has_next;
  logic [SEL_W-1:0]   first_idx;
  logic [SEL_W-1:0]   unused_act_lowest;
  logic [SEL_W-1:0]   unused_en_next;
  logic               unused_en_has_next;

  // Walks the latched mask for the current sweep.
  x_adc_next_ch u_next_act (
    .mask       (act_mask_q),
    .cur        (sel_q),
    .next_idx   (next_idx),
    .has_next   (has_next),
    .lowest_idx (unused_act_lowest)
  );

  // First channel of a freshly latched mask (sweep start or wrap).
  x_adc_next_ch u_first_en (
    .mask       (ch_enable),
    .cur        ('0),
    .next_idx   (unused_en_next),
    .has_next   (unused_en_has_next),
    .lowest_idx (first_idx)
  );

  always_comb begin
    state_d        = state_q;
    sel_d          = sel_q;
    cnt_d          = cnt_q;
    act_mask_d     = act_mask_q;
    dwell_l_d      = dwell_l_q;
    single_l_d     = single_l_q;
    stop_pending_d = stop_pending_q;
    issue          = 1'b0;
    sweep_end      = 1'b0;
    err            = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (ch_enable != '0) begin
            act_mask_d     = ch_enable;
            dwell_l_d      = dwell;
            single_l_d     = single;
            stop_pending_d = stop;
            sel_d          = first_idx;
            cnt_d          = dwell;
            state_d        = SCAN;
          end else begin
            err = 1'b1;
          end
        end
      end
      SCAN: begin
        stop_pending_d = stop_pending_q | stop;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          issue = 1'b1;
          if (has_next) begin
            sel_d = next_idx;
            cnt_d = dwell_l_q;
          end else begin
            sweep_end = 1'b1;
            if (single_l_q || stop_pending_q || stop) begin
              state_d        = IDLE;
              stop_pending_d = 1'b0;
            end else begin
              // Mask and dwell changes only take effect at the sweep boundary.
              act_mask_d = ch_enable;
              dwell_l_d  = dwell;
              if (ch_enable == '0) begin
                err     = 1'b1;
                state_d = IDLE;
              end else begin
                sel_d = first_idx;
                cnt_d = dwell;
              end
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    sample_valid_d = issue;
    sample_ch_d    = sel_q;
    sweep_done_d   = issue & sweep_end;
    err_empty_d    = err;
  end

  always_ff @(posedge clk or posedge GlobalReset) begin
    if (GlobalReset) begin
      state_q        <= IDLE;
      sel_q          <= '0;
      cnt_q          <= '0;
      act_mask_q     <= '0;
      dwell_l_q      <= '0;
      single_l_q     <= 1'b0;
      stop_pending_q <= 1'b0;
      sample_valid_q <= 1'b0;
      sample_ch_q    <= '0;
      sweep_done_q   <= 1'b0;
      err_empty_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      sel_q          <= sel_d;
      cnt_q          <= cnt_d;
      act_mask_q     <= act_mask_d;
      dwell_l_q      <= dwell_l_d;
      single_l_q     <= single_l_d;
      stop_pending_q <= stop_pending_d;
      sample_valid_q <= sample_valid_d;
      sample_ch_q    <= sample_ch_d;
      sweep_done_q   <= sweep_done_d;
      err_empty_q    <= err_empty_d;
    end
  end

  assign x_adc_select = sel_q;
  assign sample_valid = sample_valid_q;
  assign sample_ch    = sample_ch_q;
  assign sweep_done   = sweep_done_q;
  assign err_empty    = err_empty_q;
  assign busy         = (state_q == SCAN);

endmodule

// File: tb/tb_x_adc_sweep_sched.sv
// Scoreboard bench for x_adc_sweep_sched: directed sweeps push expected samples,
// a negedge monitor pops and compares each presented sample.
module tb_x_adc_sweep_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ch_enable;
  logic [7:0]  dwell;
  logic        start;
  logic        stop;
  logic        single;
  logic [4:0]  x_adc_select;
  logic        sample_valid;
  logic [4:0]  sample_ch;
  logic        sweep_done;
  logic        busy;
  logic        err_empty;

  typedef struct {
    logic [4:0] ch;
    logic       done;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp   = 0;
  int   n_bad   = 0;
  int   err_cnt = 0;

  always #5 clk = ~clk;

  x_adc_sweep_sched dut (
    .clk          (clk),
    .GlobalReset  (rst),
    .ch_enable    (ch_enable),
    .dwell        (dwell),
    .start        (start),
    .stop         (stop),
    .single       (single),
    .x_adc_select (x_adc_select),
    .sample_valid (sample_valid),
    .sample_ch    (sample_ch),
    .sweep_done   (sweep_done),
    .busy         (busy),
    .err_empty    (err_empty)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  task automatic push(input logic [4:0] ch, input logic done);
    exp_t e;
    e.ch   = ch;
    e.done = done;
    exp_q.push_back(e);
  endtask

  // Called just after a posedge; the start edge is the next posedge.
  task automatic pulse_start(input logic stp);
    start = 1'b1;
    stop  = stp;
    @(posedge clk);
    #1;
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int k;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!busy) break;
    end
    if (k == 200) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: busy still %0b, expected 0", nm, busy);
    end
    repeat (3) @(negedge clk);
    chk({nm, "_busy_idle"}, 32'(busy), 32'd0);
    chk({nm, "_queue_drained"}, 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: every presented sample must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (err_empty) err_cnt++;
      if (sweep_done && !sample_valid) begin
        n_cmp++;
        n_bad++;
        $display("FAIL done_without_valid: sweep_done=1, sample_valid=0");
      end
      if (sample_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_sample: got ch %0d done %0b, expected none", sample_ch, sweep_done);
        end else begin
          e = exp_q.pop_front();
          $display("sample ch=%0d done=%0b (expect ch=%0d done=%0b)", sample_ch, sweep_done, e.ch, e.done);
          chk("sample_ch", 32'(sample_ch), 32'(e.ch));
          chk("sweep_done", 32'(sweep_done), 32'(e.done));
        end
      end
    end
  end

  initial begin
    int e0;
    rst = 1'b1; ch_enable = '0; dwell = '0; start = 1'b0; stop = 1'b0; single = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_select", 32'(x_adc_select), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(sample_valid), 32'd0);
    chk("rst_err", 32'(err_empty), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 1: single sweep, sparse mask with wrap at 31
    ch_enable = 32'h8000_0005; dwell = 8'd0; single = 1'b1;
    push(5'd0, 1'b0); push(5'd2, 1'b0); push(5'd31, 1'b1);
    pulse_start(1'b0);
    @(negedge clk); chk("t1_sel0", 32'(x_adc_select), 32'd0);  chk("t1_busy0", 32'(busy), 32'd1);
    @(negedge clk); chk("t1_sel2", 32'(x_adc_select), 32'd2);  chk("t1_busy1", 32'(busy), 32'd1);
    @(negedge clk); chk("t1_sel31", 32'(x_adc_select), 32'd31); chk("t1_busy2", 32'(busy), 32'd1);
    @(negedge clk); chk("t1_busy_fall", 32'(busy), 32'd0); chk("t1_sel_hold", 32'(x_adc_select), 32'd31);
    wait_idle("t1");

    // 2: dwell=2 continuous, stop while select=0
    ch_enable = 32'h3; dwell = 8'd2; single = 1'b0;
    push(5'd0, 1'b0); push(5'd1, 1'b1);
    pulse_start(1'b0);
    stop = 1'b1;
    @(negedge clk); chk("t2_sel_a", 32'(x_adc_select), 32'd0);
    @(posedge clk); #1; stop = 1'b0;
    @(negedge clk); chk("t2_sel_b", 32'(x_adc_select), 32'd0);
    @(negedge clk); chk("t2_sel_c", 32'(x_adc_select), 32'd0);
    @(negedge clk); chk("t2_sel_d", 32'(x_adc_select), 32'd1);
    wait_idle("t2");

    // 3: empty mask start
    ch_enable = 32'h0; dwell = 8'd0;
    e0 = err_cnt;
    pulse_start(1'b0);
    repeat (5) @(negedge clk);
    chk("t3_err_pulses", 32'(err_cnt - e0), 32'd1);
    chk("t3_busy", 32'(busy), 32'd0);
    wait_idle("t3");

    // 4: continuous ch0, mask changed mid-dwell to ch1
    ch_enable = 32'h1; dwell = 8'd3; single = 1'b0;
    push(5'd0, 1'b1); push(5'd1, 1'b1);
    pulse_start(1'b0);
    @(posedge clk); #1; ch_enable = 32'h2;
    repeat (4) @(negedge clk);
    chk("t4_sel_no_gap", 32'(x_adc_select), 32'd1);
    chk("t4_busy", 32'(busy), 32'd1);
    @(posedge clk); #1; stop = 1'b1;
    @(posedge clk); #1; stop = 1'b0;
    wait_idle("t4");

    // 5: asynchronous reset mid-scan
    ch_enable = 32'h10; dwell = 8'd5;
    pulse_start(1'b0);
    #1;
    chk("t5_sel_pre", 32'(x_adc_select), 32'd4);
    chk("t5_busy_pre", 32'(busy), 32'd1);
    #1; rst = 1'b1;
    #1;
    chk("t5_sel_async", 32'(x_adc_select), 32'd0);
    chk("t5_busy_async", 32'(busy), 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("t5_busy_after", 32'(busy), 32'd0);
    chk("t5_sel_after", 32'(x_adc_select), 32'd0);
    @(posedge clk); #1;

    // 6: start and stop together -> exactly one sweep
    ch_enable = 32'hF0; dwell = 8'd0; single = 1'b0;
    push(5'd4, 1'b0); push(5'd5, 1'b0); push(5'd6, 1'b0); push(5'd7, 1'b1);
    pulse_start(1'b1);
    wait_idle("t6");

    // 7: mask cleared before wrap in continuous mode
    ch_enable = 32'h1; dwell = 8'd1; single = 1'b0;
    push(5'd0, 1'b1);
    e0 = err_cnt;
    pulse_start(1'b0);
    ch_enable = 32'h0;
    wait_idle("t7");
    chk("t7_err_pulses", 32'(err_cnt - e0), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
